// File: rtl/seg_595_monitor.sv
// ---------------------------------------------------------------------------
// seg_595_monitor
//
// Receive-side checker for a 74HC595 dynamic-scan display driver. It samples
// the four serial pins on sys_clk, rebuilds each 14-bit scan word
// ({seg[7:0], sel[5:0]}, both active-low), and decodes the segment pattern
// back to a 4-bit digit code. Once all six digit positions have been seen,
// it publishes the assembled frame together with its decimal points.
//
// Parameters
//   SYNC_STAGES   : synchroniser depth on every pin input (2 or more)
//   FRAME_TIMEOUT : sys_clk cycles without a latch before stale asserts
//
// Ports
//   sys_clk     : system clock
//   sys_rst_n   : asynchronous active-low reset
//   shcp        : 595 shift clock pin (asynchronous, sampled)
//   ds          : 595 serial data pin (asynchronous, sampled)
//   stcp        : 595 storage latch pin (asynchronous, sampled)
//   oe          : 595 output enable pin, active-low (asynchronous, sampled)
//   digits      : last complete frame, digit i at [4i+3:4i]
//   dp          : last complete frame decimal points, 1 = lit
//   frame_valid : 1-cycle pulse when digits/dp update
//   disp_on     : synchronised, registered ~oe
//   len_err     : 1-cycle pulse, latch seen with bit count != 14
//   sel_err     : 1-cycle pulse, latched select not exactly one digit
//   code_err    : 1-cycle pulse, segment pattern not in the decode table
//   stale       : no latch for FRAME_TIMEOUT cycles
// ---------------------------------------------------------------------------
module seg_595_monitor #(
  parameter int SYNC_STAGES   = 2,
  parameter int FRAME_TIMEOUT = 50_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        shcp,
  input  logic        ds,
  input  logic        stcp,
  input  logic        oe,
  output logic [23:0] digits,
  output logic [5:0]  dp,
  output logic        frame_valid,
  output logic        disp_on,
  output logic        len_err,
  output logic        sel_err,
  output logic        code_err,
  output logic        stale
);

  // Counter wide enough to hold FRAME_TIMEOUT itself.
  localparam int TW = (FRAME_TIMEOUT < 2) ? 1 : $clog2(FRAME_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(FRAME_TIMEOUT);

  // Pin bit positions inside the synchroniser vector.
  localparam int P_SHCP = 0;
  localparam int P_DS   = 1;
  localparam int P_STCP = 2;
  localparam int P_OE   = 3;

  // -------------------------------------------------------------------------
  // Input synchronisers: all four pins travel together through the chain so
  // ds stays aligned with the shcp edge that samples it.
  // -------------------------------------------------------------------------
  logic [3:0]                  pins_raw;
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  pins_s;
  logic [1:0]                  edge_prev_q, edge_prev_d;   // {stcp, shcp}

  assign pins_raw = {oe, stcp, ds, shcp};
  assign pins_s   = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = pins_raw;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    edge_prev_d = {pins_s[P_STCP], pins_s[P_SHCP]};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q      <= '0;
      edge_prev_q <= '0;
    end else begin
      sync_q      <= sync_d;
      edge_prev_q <= edge_prev_d;
    end
  end

  logic shcp_rise, stcp_rise, ds_s, oe_s;
  assign shcp_rise = pins_s[P_SHCP] & ~edge_prev_q[0];
  assign stcp_rise = pins_s[P_STCP] & ~edge_prev_q[1];
  assign ds_s      = pins_s[P_DS];
  assign oe_s      = pins_s[P_OE];

  // -------------------------------------------------------------------------
  // Deserialiser and latch capture
  // -------------------------------------------------------------------------
  logic [13:0] sr_q, sr_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [13:0] word_q, word_d;
  logic        cap_vld_q, cap_vld_d;
  logic        len_err_q, len_err_d;

  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    cap_vld_d = 1'b0;
    len_err_d = 1'b0;

    // The latch always sees the register contents from before any shift in
    // the same cycle, exactly like the real 595 storage register.
    if (stcp_rise) begin
      word_d    = sr_q;
      cap_vld_d = 1'b1;
      len_err_d = (bit_cnt_q != 4'd14);
      bit_cnt_d = 4'd0;
    end

    if (shcp_rise) begin
      sr_d = {sr_q[12:0], ds_s};
      if (stcp_rise) begin
        // This bit is the first of the next word.
        bit_cnt_d = 4'd1;
      end else if (bit_cnt_q != 4'd15) begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      word_q    <= '0;
      cap_vld_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
      cap_vld_q <= cap_vld_d;
      len_err_q <= len_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Segment / select decode of the captured word
  // -------------------------------------------------------------------------
  logic [7:0] seg_w;
  logic [5:0] sel_w;
  logic [5:0] sel_hot;
  logic       sel_ok;
  logic [3:0] dec_code;
  logic       dec_known;

  assign seg_w   = word_q[13:6];
  assign sel_w   = word_q[5:0];
  assign sel_hot = ~sel_w;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
  assign sel_ok  = (sel_hot != 6'd0) && ((sel_hot & (sel_hot - 6'd1)) == 6'd0);

  // seg[7] is the decimal point and is decoded separately.
  always_comb begin
    dec_known = 1'b1;
    dec_code  = 4'hF;
    case (seg_w[6:0])
      7'h40:   dec_code = 4'h0;
      7'h79:   dec_code = 4'h1;
      7'h24:   dec_code = 4'h2;
      7'h30:   dec_code = 4'h3;
      7'h19:   dec_code = 4'h4;
      7'h12:   dec_code = 4'h5;
      7'h02:   dec_code = 4'h6;
      7'h78:   dec_code = 4'h7;
      7'h00:   dec_code = 4'h8;
      7'h10:   dec_code = 4'h9;
      7'h3F:   dec_code = 4'hA;   // minus sign
      7'h7F:   dec_code = 4'hF;   // blank digit
      default: begin
        dec_code  = 4'hF;
        dec_known = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Frame assembly
  // -------------------------------------------------------------------------
  logic [23:0] work_q, work_d;
  logic [5:0]  work_dp_q, work_dp_d;
  logic [5:0]  seen_q, seen_d;
  logic [5:0]  seen_upd;
  logic [23:0] digits_q, digits_d;
  logic [5:0]  dp_q, dp_d;
  logic        frame_valid_q, frame_valid_d;
  logic        sel_err_q, sel_err_d;
  logic        code_err_q, code_err_d;

  always_comb begin
    work_d        = work_q;
    work_dp_d     = work_dp_q;
    seen_d        = seen_q;
    seen_upd      = seen_q;
    digits_d      = digits_q;
    dp_d          = dp_q;
    frame_valid_d = 1'b0;
    sel_err_d     = 1'b0;
    code_err_d    = 1'b0;

    if (cap_vld_q) begin
      // Pattern and select errors are independent and may both fire.
      code_err_d = ~dec_known;
      sel_err_d  = ~sel_ok;

      if (sel_ok) begin
        for (int i = 0; i < 6; i++) begin
          if (sel_hot[i]) begin
            work_d[4*i +: 4] = dec_code;
            work_dp_d[i]     = ~seg_w[7];
          end
        end
        seen_upd = seen_q | sel_hot;

        // Publish including the digit being written this cycle.
        if (seen_upd == 6'h3F) begin
          digits_d      = work_d;
          dp_d          = work_dp_d;
          frame_valid_d = 1'b1;
          seen_d        = 6'd0;
        end else begin
          seen_d = seen_upd;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      work_q        <= 24'hFFFFFF;
      work_dp_q     <= '0;
      seen_q        <= '0;
      digits_q      <= 24'hFFFFFF;
      dp_q          <= '0;
      frame_valid_q <= 1'b0;
      sel_err_q     <= 1'b0;
      code_err_q    <= 1'b0;
    end else begin
      work_q        <= work_d;
      work_dp_q     <= work_dp_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      frame_valid_q <= frame_valid_d;
      sel_err_q     <= sel_err_d;
      code_err_q    <= code_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Display enable and latch timeout
  // -------------------------------------------------------------------------
  logic          disp_on_q, disp_on_d;
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    disp_on_d = ~oe_s;
    if (stcp_rise) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_MAX) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      disp_on_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      disp_on_q <= disp_on_d;
      tmo_q     <= tmo_d;
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign frame_valid = frame_valid_q;
  assign disp_on     = disp_on_q;
  assign len_err     = len_err_q;
  assign sel_err     = sel_err_q;
  assign code_err    = code_err_q;
  assign stale       = (tmo_q == TMO_MAX);

endmodule
